baud_gen_os: RTL and testbench

- Parametrised successor to the UART divisor-latch baud generator.
- Produces two enables from one programmable divisor:
  - en_os: oversample tick, feeds the receiver.
  - en_bit: one tick per OVERSAMPLE en_os ticks, feeds the transmitter.
- The divisor is written over the SPART data bus as low/high halves and committed atomically on the high write.
- Committed divisor is readable back over the same bus.

---
 rtl/baud_gen_os.sv | 140 ++++++++++++++
 tb/tb_baud_gen_os.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_os.sv
// ----------------------------------------------------------------------------
// baud_gen_os
//
// Programmable baud generator with an oversampling stage. A single divisor,
// written over the SPART data bus as a low half followed by a high half,
// sets the period of the oversample tick (en_os). Every OVERSAMPLE oversample
// ticks, a bit tick (en_bit) is also issued.
//
// Parameters:
//   BUS_WIDTH  - width of the data bus; the divisor is twice this wide
//   OVERSAMPLE - en_os ticks per en_bit tick (must be >= 2)
//   RESET_DIV  - divisor loaded on reset
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   wr_en      - bus write strobe, one cycle per write
//   ioaddr     - register select: 2'b10 divisor low, 2'b11 divisor high
//   data_bus   - write data
//   rd_data    - combinational readback of the committed divisor half
//   en_os      - oversample enable, one-cycle pulse every div+1 clocks
//   en_bit     - bit enable, coincident with every OVERSAMPLE-th en_os
//   lo_pending - a low half has been staged but not yet committed
// ----------------------------------------------------------------------------
module baud_gen_os #(
    parameter int BUS_WIDTH  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int RESET_DIV  = 162
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           ioaddr,
    input  logic [BUS_WIDTH-1:0] data_bus,
    output logic [BUS_WIDTH-1:0] rd_data,
    output logic                 en_os,
    output logic                 en_bit,
    output logic                 lo_pending
);

    localparam int DW  = 2 * BUS_WIDTH;
    localparam int OSW = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0]  RESET_DIV_W = DW'(RESET_DIV);
    localparam logic [DW-1:0]  CNT_ONE     = DW'(1);
    localparam logic [OSW-1:0] OS_LAST     = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_ONE      = OSW'(1);

    localparam logic [1:0] ADDR_DB_LOW  = 2'b10;
    localparam logic [1:0] ADDR_DB_HIGH = 2'b11;

    logic [BUS_WIDTH-1:0] lo_stage;
    logic [DW-1:0]        div;
    logic [DW-1:0]        cnt;
    logic [OSW-1:0]       os_cnt;

    logic                 lo_wr;
    logic                 commit;
    logic [DW-1:0]        new_div;

    // Decode of the two bus writes; the high write commits the whole divisor
    // together with whatever low half is currently staged.
    always_comb begin
        lo_wr   = wr_en && (ioaddr == ADDR_DB_LOW);
        commit  = wr_en && (ioaddr == ADDR_DB_HIGH);
        new_div = {data_bus, lo_stage};
    end

    // Tick decode straight from registers. A zero divisor would otherwise
    // fire every clock, so it is treated as "generator off".
    always_comb begin
        en_os  = (cnt == '0) && (div != '0);
        en_bit = en_os && (os_cnt == OS_LAST);
    end

    // Readback only ever shows the committed divisor, never the staged half.
    always_comb begin
        rd_data = '0;
        case (ioaddr)
            ADDR_DB_LOW:  rd_data = div[BUS_WIDTH-1:0];
            ADDR_DB_HIGH: rd_data = div[DW-1:BUS_WIDTH];
            default:      rd_data = '0;
        endcase
    end

    // Low-half staging register and its pending flag. Staging never touches
    // the running divisor, so the tick stream is undisturbed until commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_stage   <= RESET_DIV_W[BUS_WIDTH-1:0];
            lo_pending <= 1'b0;
        end else if (commit) begin
            lo_pending <= 1'b0;
        end else if (lo_wr) begin
            lo_stage   <= data_bus;
            lo_pending <= 1'b1;
        end
    end

    // Committed divisor, updated atomically on the high-half write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= RESET_DIV_W;
        end else if (commit) begin
            div <= new_div;
        end
    end

    // Down counter. A commit restarts the period from the new divisor even if
    // a tick is being output this cycle; otherwise it reloads on reaching zero.
    // With div == 0 the reload keeps it parked at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RESET_DIV_W;
        end else if (commit) begin
            cnt <= new_div;
        end else if (cnt == '0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Oversample counter advances once per en_os and wraps after the last
    // sub-tick; a commit realigns the bit boundary with the new divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os_cnt <= '0;
        end else if (commit) begin
            os_cnt <= '0;
        end else if (en_os) begin
            if (os_cnt == OS_LAST) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + OS_ONE;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_os.sv
// ----------------------------------------------------------------------------
// tb_baud_gen_os
//
// Directed bench for baud_gen_os with default parameters (8-bit bus,
// OVERSAMPLE 16, RESET_DIV 162). Inputs are driven and outputs sampled on the
// falling clock edge; gaps are counted in rising edges.
// ----------------------------------------------------------------------------
module tb_baud_gen_os;

    localparam int LIMIT = 4000;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] ioaddr;
    logic [7:0] data_bus;
    logic [7:0] rd_data;
    logic       en_os;
    logic       en_bit;
    logic       lo_pending;

    int compared;
    int mismatched;

    baud_gen_os #(
        .BUS_WIDTH (8),
        .OVERSAMPLE(16),
        .RESET_DIV (162)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .ioaddr    (ioaddr),
        .data_bus  (data_bus),
        .rd_data   (rd_data),
        .en_os     (en_os),
        .en_bit    (en_bit),
        .lo_pending(lo_pending)
    );

    // Free-running 100 MHz-style clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One bus write. Called at a falling edge; the write lands on the next
    // rising edge and the task returns at the falling edge after it.
    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
        wr_en    = 1'b1;
        ioaddr   = addr;
        data_bus = data;
        @(negedge clk);
        wr_en    = 1'b0;
        ioaddr   = 2'b00;
        data_bus = 8'h00;
    endtask

    // Combinational readback check with no write in flight.
    task automatic readCheck(input string tag, input logic [1:0] addr,
                             input logic [7:0] expected);
        ioaddr = addr;
        #1;
        checkOutput(tag, {24'h0, rd_data}, {24'h0, expected});
        ioaddr = 2'b00;
    endtask

    // Rising edges until en_os is seen high (at least one edge).
    task automatic nextOs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (en_os !== 1'b1 && n < LIMIT);
    endtask

    // Rising edges until en_bit is seen high (at least one edge).
    task automatic nextBit(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (en_bit !== 1'b1 && n < LIMIT);
    endtask

    initial begin
        int gap;
        logic seen;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        ioaddr     = 2'b00;
        data_bus   = 8'h00;

        // ---- Scenario 1: reset defaults, divisor 162 ----
        #3;
        checkOutput("s1 en_os in reset", {31'h0, en_os}, 32'h0);
        checkOutput("s1 en_bit in reset", {31'h0, en_bit}, 32'h0);
        checkOutput("s1 lo_pending in reset", {31'h0, lo_pending}, 32'h0);
        readCheck("s1 rd hi", 2'b11, 8'h00);
        readCheck("s1 rd lo", 2'b10, 8'hA2);
        readCheck("s1 rd other", 2'b01, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        nextOs(gap);
        checkOutput("s1 first en_os", gap, 162);
        nextOs(gap);
        checkOutput("s1 en_os period", gap, 163);
        nextOs(gap);
        checkOutput("s1 en_os period 2", gap, 163);
        // Third tick seen; 13 more ticks to the 16th.
        nextBit(gap);
        checkOutput("s1 first en_bit", gap, 13 * 163);
        checkOutput("s1 en_os with en_bit", {31'h0, en_os}, 32'h1);
        nextBit(gap);
        checkOutput("s1 en_bit period", gap, 2608);

        // ---- Scenario 2: stage low 0x03, then commit high 0x00 ----
        applyStimulus(2'b10, 8'h03);
        checkOutput("s2 lo_pending set", {31'h0, lo_pending}, 32'h1);
        readCheck("s2 rd lo unchanged", 2'b10, 8'hA2);
        nextOs(gap);
        nextOs(gap);
        checkOutput("s2 period while staged", gap, 163);
        applyStimulus(2'b11, 8'h00);
        checkOutput("s2 lo_pending clear", {31'h0, lo_pending}, 32'h0);
        readCheck("s2 rd lo new", 2'b10, 8'h03);
        nextOs(gap);
        checkOutput("s2 first en_os", gap, 3);
        nextOs(gap);
        checkOutput("s2 en_os period", gap, 4);
        nextBit(gap);
        checkOutput("s2 first en_bit", gap, 56);
        nextBit(gap);
        checkOutput("s2 en_bit period", gap, 64);

        // ---- Scenario 3: divisor 0 disables, then divisor 1 ----
        applyStimulus(2'b10, 8'h00);
        applyStimulus(2'b11, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en_os !== 1'b0 || en_bit !== 1'b0) seen = 1'b1;
        end
        checkOutput("s3 silent with div 0", {31'h0, seen}, 32'h0);
        readCheck("s3 rd lo zero", 2'b10, 8'h00);
        applyStimulus(2'b10, 8'h01);
        applyStimulus(2'b11, 8'h00);
        nextOs(gap);
        checkOutput("s3 div1 first en_os", gap, 1);
        nextOs(gap);
        checkOutput("s3 div1 period", gap, 2);
        nextOs(gap);
        checkOutput("s3 div1 period 2", gap, 2);

        // ---- Scenario 4: low write and commit coinciding with ticks ----
        applyStimulus(2'b10, 8'h03);
        applyStimulus(2'b11, 8'h00);
        nextOs(gap);
        checkOutput("s4 div3 first en_os", gap, 3);
        // Stage low 0x07 during a tick cycle; the tick stream must not move.
        applyStimulus(2'b10, 8'h07);
        nextOs(gap);
        checkOutput("s4 period with lo write", gap + 1, 4);
        checkOutput("s4 pulse before commit", {31'h0, en_os}, 32'h1);
        wr_en    = 1'b1;
        ioaddr   = 2'b11;
        data_bus = 8'h00;
        #1;
        checkOutput("s4 pulse during commit", {31'h0, en_os}, 32'h1);
        @(negedge clk);
        wr_en  = 1'b0;
        ioaddr = 2'b00;
        nextOs(gap);
        checkOutput("s4 gap after commit", gap + 1, 8);
        nextBit(gap);
        checkOutput("s4 en_bit on 16th tick", gap, 15 * 8);

        // ---- Scenario 5: two low writes, last one wins ----
        applyStimulus(2'b10, 8'h10);
        applyStimulus(2'b10, 8'h20);
        checkOutput("s5 lo_pending", {31'h0, lo_pending}, 32'h1);
        applyStimulus(2'b11, 8'h01);
        readCheck("s5 rd lo", 2'b10, 8'h20);
        readCheck("s5 rd hi", 2'b11, 8'h01);
        nextOs(gap);
        checkOutput("s5 first en_os", gap, 288);
        nextOs(gap);
        checkOutput("s5 en_os period", gap, 289);

        // ---- Scenario 6: reset mid-count with os_cnt at 9 ----
        for (int i = 0; i < 7; i++) nextOs(gap);
        repeat (100) @(negedge clk);
        applyStimulus(2'b10, 8'h55);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("s6 en_os after rst", {31'h0, en_os}, 32'h0);
        checkOutput("s6 en_bit after rst", {31'h0, en_bit}, 32'h0);
        checkOutput("s6 lo_pending after rst", {31'h0, lo_pending}, 32'h0);
        readCheck("s6 rd lo after rst", 2'b10, 8'hA2);
        readCheck("s6 rd hi after rst", 2'b11, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        nextOs(gap);
        checkOutput("s6 first en_os", gap, 162);
        nextBit(gap);
        checkOutput("s6 first en_bit", gap, 2607 - 162);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
